mod7_stream_accumulator: RTL and testbench

//   Sequential stage upstream of mod7_reminder's consumer side: computes remainder mod 7 of an

---
 rtl/mod7_stream_accumulator.sv | 137 +++++++++++++
 tb/tb_mod7_stream_accumulator.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mod7_stream_accumulator.sv
// mod7_stream_accumulator
//   Computes the remainder mod 7 of an unsigned number of any length. The number
//   arrives as 4-bit nibbles, most significant nibble first. For each accepted
//   nibble the remainder updates as r <= (2*r + nibble) mod 7, because 16 mod 7 = 2.
//   Both sides use a valid/ready handshake. Only one frame is in flight at a time.
//
//   Optional feature: define MOD7_LEN_CHECK_EN to flag frames longer than
//   MAX_NIBBLES on err_o. When the macro is undefined, err_o is tied to 0.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   in_nib_i     nibble {A,B,C,D}, A = MSB
//   in_valid_i   in_nib_i valid
//   in_last_i    final nibble of the frame
//   in_ready_o   accumulator can accept a nibble
//   rem_o        {X1,X2,X3} remainder 0..6, valid while out_valid_o
//   nib_cnt_o    nibbles accepted in the reported frame (saturates at MAX_NIBBLES)
//   err_o        frame exceeded MAX_NIBBLES (MOD7_LEN_CHECK_EN builds only)
//   out_valid_o  result valid
//   out_ready_i  consumer accepts result
//
// States
//   IDLE  | no nibble of the current frame accepted yet, r = 0
//   ACCUM | frame in progress, waiting for more nibbles
//   HOLD  | result presented, waiting for the consumer
module mod7_stream_accumulator #(
  parameter  int MAX_NIBBLES = 16,
  localparam int CNT_W       = $clog2(MAX_NIBBLES + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       in_nib_i,
  input  logic             in_valid_i,
  input  logic             in_last_i,
  output logic             in_ready_o,
  output logic [2:0]       rem_o,
  output logic [CNT_W-1:0] nib_cnt_o,
  output logic             err_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t             state_q, state_d;
  logic [2:0]         r_q, r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;
  logic [4:0]         sum;
  logic [2:0]         r_next;
  logic [CNT_W-1:0]   cnt_inc;
  logic               cnt_full;

  // Reduce a value in 0..27 to 0..6. Because 8 mod 7 = 1, the bits above bit 2
  // fold back in as a plain add. Two folds bring the value down to 0..7, and
  // then 7 maps to 0.
  function automatic logic [2:0] mod7_fold(input logic [4:0] s);
    logic [3:0] t;
    logic [2:0] u;
    t = {2'b00, s[4:3]} + {1'b0, s[2:0]};
    u = 3'(t[3]) + t[2:0];
    return (u == 3'd7) ? 3'd0 : u;
  endfunction

  // In IDLE r_q is 0, so the same update gives nib mod 7 for the first nibble.
  assign sum      = {1'b0, r_q, 1'b0} + {1'b0, in_nib_i};
  assign r_next   = mod7_fold(sum);
  assign cnt_full = (cnt_q == CNT_W'(MAX_NIBBLES));
  assign cnt_inc  = cnt_full ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    in_ready_o  = (state_q != HOLD);
    out_valid_o = (state_q == HOLD);
    accept      = in_valid_i & in_ready_o;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          r_d     = r_next;
          cnt_d   = cnt_inc;
          state_d = in_last_i ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_ready_i) begin
          r_d     = 3'd0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      r_q     <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MOD7_LEN_CHECK_EN
  logic err_q, err_d;

  // err is sticky for the frame. It is set when a nibble arrives after the
  // counter has already saturated, and it clears when the result is transferred.
  always_comb begin
    err_d = err_q;
    if (state_q == HOLD) begin
      if (out_ready_i) err_d = 1'b0;
    end else if (accept && cnt_full) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign rem_o     = r_q;
  assign nib_cnt_o = cnt_q;

endmodule

// File: tb/tb_mod7_stream_accumulator.sv
module tb_mod7_stream_accumulator;

  localparam int MAXN = 4;
  localparam int CW   = $clog2(MAXN + 1);

`ifdef MOD7_LEN_CHECK_EN
  localparam logic EXP_LEN_ERR = 1'b1;
`else
  localparam logic EXP_LEN_ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    in_nib;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [2:0]    rem;
  logic [CW-1:0] nib_cnt;
  logic          err;
  logic          out_valid;
  logic          out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod7_stream_accumulator #(.MAX_NIBBLES(MAXN)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_nib_i    (in_nib),
    .in_valid_i  (in_valid),
    .in_last_i   (in_last),
    .in_ready_o  (in_ready),
    .rem_o       (rem),
    .nib_cnt_o   (nib_cnt),
    .err_o       (err),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Drives one nibble for a single cycle and returns at the
  // following negedge with in_valid low.
  task automatic send(input logic [3:0] nib, input logic last);
    in_nib   = nib;
    in_last  = last;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Checks the result one cycle after the last nibble was accepted.
  task automatic chk_result(input string tag, input logic [2:0] r, input logic [CW-1:0] c,
                            input logic e);
    chk({tag, "_valid"}, 8'(out_valid), 8'd1);
    chk({tag, "_rem"},   8'(rem),       8'(r));
    chk({tag, "_cnt"},   8'(nib_cnt),   8'(c));
    chk({tag, "_err"},   8'(err),       8'(e));
    chk({tag, "_rdy"},   8'(in_ready),  8'd0);
  endtask

  task automatic transfer(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_xfer_valid"}, 8'(out_valid), 8'd0);
    chk({tag, "_xfer_rdy"},   8'(in_ready),  8'd1);
    chk({tag, "_xfer_rem"},   8'(rem),       8'd0);
    chk({tag, "_xfer_cnt"},   8'(nib_cnt),   8'd0);
    chk({tag, "_xfer_err"},   8'(err),       8'd0);
  endtask

  initial begin
    rst = 1'b1; in_nib = 4'h0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy",   8'(in_ready),  8'd1);
    chk("rst_valid", 8'(out_valid), 8'd0);
    chk("rst_rem",   8'(rem),       8'd0);
    chk("rst_cnt",   8'(nib_cnt),   8'd0);
    chk("rst_err",   8'(err),       8'd0);

    // single-nibble frames
    send(4'h2, 1'b1); chk_result("f2", 3'd2, CW'(1), 1'b0); transfer("f2");
    send(4'hB, 1'b1); chk_result("fB", 3'd4, CW'(1), 1'b0); transfer("fB");
    send(4'hF, 1'b1); chk_result("fF", 3'd1, CW'(1), 1'b0); transfer("fF");
    send(4'hA, 1'b1); chk_result("fA", 3'd3, CW'(1), 1'b0); transfer("fA");
    send(4'hC, 1'b1); chk_result("fC", 3'd5, CW'(1), 1'b0); transfer("fC");

    // 0x1234 = 4660 with a 3-cycle gap mid-frame
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    repeat (3) @(negedge clk);
    chk("gap_rem",   8'(rem),       8'd4);
    chk("gap_cnt",   8'(nib_cnt),   8'd2);
    chk("gap_valid", 8'(out_valid), 8'd0);
    send(4'h3, 1'b0);
    send(4'h4, 1'b1);
    chk_result("f1234", 3'd5, CW'(4), 1'b0); transfer("f1234");

    send(4'h7, 1'b0); send(4'h0, 1'b0); send(4'h0, 1'b1);
    chk_result("f700", 3'd0, CW'(3), 1'b0); transfer("f700");

    // 0xFFFF, then hold with out_ready low while in_valid pulses are ignored
    send(4'hF, 1'b0); send(4'hF, 1'b0); send(4'hF, 1'b0); send(4'hF, 1'b1);
    chk_result("fFFFF", 3'd1, CW'(4), 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_nib   = 4'h3;
      in_last  = 1'b1;
      @(negedge clk);
      chk("hold_valid", 8'(out_valid), 8'd1);
      chk("hold_rem",   8'(rem),       8'd1);
      chk("hold_cnt",   8'(nib_cnt),   8'd4);
      chk("hold_rdy",   8'(in_ready),  8'd0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    transfer("hold");

    // reset in the middle of a frame
    send(4'h1, 1'b0); send(4'h2, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_rem", 8'(rem),       8'd0);
    chk("mid_rst_cnt", 8'(nib_cnt),   8'd0);
    chk("mid_rst_rdy", 8'(in_ready),  8'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(4'h3, 1'b1); chk_result("f3", 3'd3, CW'(1), 1'b0); transfer("f3");

    // over-length frame: the count saturates and the remainder stays exact
    send(4'h1, 1'b0); send(4'h0, 1'b0); send(4'h0, 1'b0); send(4'h0, 1'b0);
    chk("len_pre_err", 8'(err), 8'd0);
    send(4'h0, 1'b1);
    chk_result("flen", 3'd2, CW'(MAXN), EXP_LEN_ERR); transfer("flen");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
